// File: rtl/ps2_keyboard_pkg.sv
// ps2_keyboard_pkg: set-2 scan codes, ASCII codes, decoder states and key translation maps
package ps2_keyboard_pkg;
  typedef enum logic [7:0] {
    SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23, SC_E = 8'h24, SC_F = 8'h2B,
    SC_G = 8'h34, SC_H = 8'h33, SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B,
    SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D, SC_Q = 8'h15, SC_R = 8'h2D,
    SC_S = 8'h1B, SC_T = 8'h2C, SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22,
    SC_Y = 8'h35, SC_Z = 8'h1A,
    SC_0 = 8'h45, SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26, SC_4 = 8'h25, SC_5 = 8'h2E,
    SC_6 = 8'h36, SC_7 = 8'h3D, SC_8 = 8'h3E, SC_9 = 8'h46,
    SC_BACKTICK = 8'h0E, SC_MINUS = 8'h4E, SC_EQUAL = 8'h55, SC_LBRACKET = 8'h54,
    SC_RBRACKET = 8'h5B, SC_BACKSLASH = 8'h5D, SC_SEMICOLON = 8'h4C, SC_QUOTE = 8'h52,
    SC_COMMA = 8'h41, SC_PERIOD = 8'h49, SC_SLASH = 8'h4A,
    SC_SPACE = 8'h29, SC_ENTER = 8'h5A, SC_BACKSPACE = 8'h66, SC_TAB = 8'h0D,
    SC_LSHIFT = 8'h12, SC_RSHIFT = 8'h59, SC_CTRL = 8'h14, SC_ALT = 8'h11, SC_CAPSLOCK = 8'h58,
    SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74,
    SC_PREFIX_EXT = 8'hE0, SC_PREFIX_BREAK = 8'hF0
  } scan_code_t;

  typedef enum logic [7:0] {
    ASC_NUL = 8'h00, ASC_BS = 8'h08, ASC_TAB = 8'h09, ASC_CR = 8'h0D, ASC_SPACE = 8'h20,
    ASC_UP = 8'h80, ASC_DOWN = 8'h81, ASC_LEFT = 8'h82, ASC_RIGHT = 8'h83
  } ascii_code_t;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} dec_state_t;

  function automatic logic [7:0] base_map(input logic ext, input logic [7:0] code);
    if (ext) begin
      case (code)
        SC_UP: return ASC_UP; SC_DOWN: return ASC_DOWN;
        SC_LEFT: return ASC_LEFT; SC_RIGHT: return ASC_RIGHT;
        default: return ASC_NUL;
      endcase
    end
    case (code)
      SC_A: return "a"; SC_B: return "b"; SC_C: return "c"; SC_D: return "d"; SC_E: return "e";
      SC_F: return "f"; SC_G: return "g"; SC_H: return "h"; SC_I: return "i"; SC_J: return "j";
      SC_K: return "k"; SC_L: return "l"; SC_M: return "m"; SC_N: return "n"; SC_O: return "o";
      SC_P: return "p"; SC_Q: return "q"; SC_R: return "r"; SC_S: return "s"; SC_T: return "t";
      SC_U: return "u"; SC_V: return "v"; SC_W: return "w"; SC_X: return "x"; SC_Y: return "y";
      SC_Z: return "z";
      SC_0: return "0"; SC_1: return "1"; SC_2: return "2"; SC_3: return "3"; SC_4: return "4";
      SC_5: return "5"; SC_6: return "6"; SC_7: return "7"; SC_8: return "8"; SC_9: return "9";
      SC_BACKTICK: return 8'h60; SC_MINUS: return "-"; SC_EQUAL: return "=";
      SC_LBRACKET: return "["; SC_RBRACKET: return "]"; SC_BACKSLASH: return 8'h5C;
      SC_SEMICOLON: return ";"; SC_QUOTE: return 8'h27; SC_COMMA: return ",";
      SC_PERIOD: return "."; SC_SLASH: return "/";
      SC_SPACE: return ASC_SPACE; SC_ENTER: return ASC_CR;
      SC_BACKSPACE: return ASC_BS; SC_TAB: return ASC_TAB;
      default: return ASC_NUL;
    endcase
  endfunction

  function automatic logic [7:0] shift_map(input logic [7:0] a, input logic shift, input logic caps);
    if (a >= "a" && a <= "z") return (shift ^ caps) ? a - 8'h20 : a;
    if (!shift) return a;
    case (a)
      "1": return "!"; "2": return "@"; "3": return "#"; "4": return "$"; "5": return "%";
      "6": return "^"; "7": return "&"; "8": return "*"; "9": return "("; "0": return ")";
      "-": return "_"; "=": return "+"; "[": return "{"; "]": return "}"; ";": return ":";
      ",": return "<"; ".": return ">"; "/": return "?";
      8'h60: return 8'h7E; 8'h5C: return 8'h7C; 8'h27: return 8'h22;
      default: return a;
    endcase
  endfunction
endpackage

// File: rtl/ps2_char_fifo.sv
// ps2_char_fifo: show-ahead FIFO with occupancy count, full and empty flags
module ps2_char_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW + 1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/ps2_keyboard_ascii_buffer.sv
// ps2_keyboard_ascii_buffer: PS/2 set-2 decoder with held-key bitmap and translated character queue
module ps2_keyboard_ascii_buffer
  import ps2_keyboard_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int REPEAT_ENABLE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  scanCode,
  input  logic                        scanCodeReady,
  input  logic [7:0]                  asciiKeyAddress,
  output logic [DATA_WIDTH-1:0]       asciiKeyValue,
  output logic [7:0]                  charData,
  output logic                        charValid,
  input  logic                        charPop,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount,
  output logic                        overflow,
  output logic [3:0]                  modifiers
);
  dec_state_t state, state_next;
  logic [255:0] held;
  logic l_shift, r_shift, l_ctrl, r_ctrl, l_alt, r_alt, caps_held, caps_lock;
  logic is_ext, is_brk, key_ev, mk, shift, ctrl, push, full, empty;
  logic [7:0] base, glyph;
  always_ff @(posedge clk) state <= rst ? ST_IDLE : state_next;
  always_comb begin
    is_ext = state == ST_EXT || state == ST_EXT_BRK;
    is_brk = state == ST_BRK || state == ST_EXT_BRK;
    key_ev = scanCodeReady && (state == ST_IDLE ? scanCode != SC_PREFIX_EXT && scanCode != SC_PREFIX_BREAK
                                                : state != ST_EXT || scanCode != SC_PREFIX_BREAK);
    state_next = !scanCodeReady ? state
               : state == ST_IDLE ? (scanCode == SC_PREFIX_EXT ? ST_EXT : scanCode == SC_PREFIX_BREAK ? ST_BRK : ST_IDLE)
               : state == ST_EXT && scanCode == SC_PREFIX_BREAK ? ST_EXT_BRK : ST_IDLE;
  end
  assign base = base_map(is_ext, scanCode);
  assign mk = key_ev && !is_brk;
  assign shift = l_shift | r_shift;
  assign ctrl = l_ctrl | r_ctrl;
  assign glyph = (ctrl && base >= "a" && base <= "z") ? {3'b000, base[4:0]} : shift_map(base, shift, caps_lock);
  assign push = mk && base != ASC_NUL && (!held[base] || REPEAT_ENABLE != 0);
  assign modifiers = {caps_lock, l_alt | r_alt, ctrl, shift};
  assign charValid = !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
      {l_shift, r_shift, l_ctrl, r_ctrl, l_alt, r_alt, caps_held, caps_lock} <= '0;
      overflow <= 1'b0;
    end else begin
      if (key_ev) begin
        if (base != ASC_NUL) held[base] <= mk;
        if (!is_ext && scanCode == SC_LSHIFT) l_shift <= mk;
        if (!is_ext && scanCode == SC_RSHIFT) r_shift <= mk;
        if (scanCode == SC_CTRL) {r_ctrl, l_ctrl} <= is_ext ? {mk, l_ctrl} : {r_ctrl, mk};
        if (scanCode == SC_ALT) {r_alt, l_alt} <= is_ext ? {mk, l_alt} : {r_alt, mk};
        if (!is_ext && scanCode == SC_CAPSLOCK) begin
          caps_held <= mk;
          if (mk && !caps_held) caps_lock <= !caps_lock;
        end
      end
      if (push && full && !charPop) overflow <= 1'b1;
    end
    asciiKeyValue <= rst ? '0 : DATA_WIDTH'(held[asciiKeyAddress]);
  end
  ps2_char_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(glyph), .pop(charPop),
    .dout(charData), .count(fifoCount), .full(full), .empty(empty)
  );
endmodule

// File: tb/tb_ps2_keyboard_ascii_buffer.sv
// tb_ps2_keyboard_ascii_buffer: directed key sequences checked against a behavioural keyboard model
module tb_ps2_keyboard_ascii_buffer;
  localparam int DEPTH = 4;
  localparam int DW = 32;
  localparam logic [7:0] LET_SC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D,
    8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG_SC [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] DIG_SH [10] = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
  localparam logic [7:0] PUN_SC [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  localparam logic [7:0] PUN_B [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  localparam logic [7:0] PUN_S [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
  localparam logic [7:0] SEQ [56] = '{
    8'h12, 8'h33, 8'hF0, 8'h12, 8'h24, 8'h4B, 8'hF0, 8'h4B,
    8'h4B, 8'h44, 8'h41, 8'h29, 8'h59, 8'h1D, 8'hF0, 8'h59,
    8'h44, 8'h2D, 8'hE0, 8'h74, 8'hE0, 8'hF0, 8'h74, 8'h58,
    8'hF0, 8'h58, 8'h35, 8'h12, 8'h4E, 8'h55, 8'h52, 8'hF0,
    8'h12, 8'h4C, 8'h11, 8'hE0, 8'h11, 8'hF0, 8'h11, 8'hE0,
    8'hF0, 8'h11, 8'hE0, 8'h14, 8'h2A, 8'hE0, 8'hF0, 8'h14,
    8'h16, 8'hF0, 8'hE0, 8'h5A, 8'h66, 8'h0D, 8'h0E, 8'h75};

  logic clk = 0, rst = 1, scanCodeReady = 0, charPop = 0;
  logic [7:0] scanCode = 0, asciiKeyAddress = 0;
  logic [DW-1:0] asciiKeyValue, key_value_nr;
  logic [7:0] charData, char_data_nr;
  logic charValid, overflow, char_valid_nr, overflow_nr;
  logic [$clog2(DEPTH):0] fifoCount, fifo_count_nr;
  logic [3:0] modifiers, modifiers_nr;
  int n_checks = 0, n_fail = 0;

  logic [7:0] tbl [256], etbl [256], stbl [256];
  logic [7:0] q [$];
  bit [255:0] m_held;
  bit m_ext, m_brk, m_ls, m_rs, m_lc, m_rc, m_la, m_ra, m_caps, m_caps_h, m_ovf, m_valid, pend;
  logic [7:0] pend_c;
  logic [31:0] m_key;

  always #5 clk = ~clk;

  ps2_keyboard_ascii_buffer #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .REPEAT_ENABLE(1)) dut (
    .clk(clk), .rst(rst), .scanCode(scanCode), .scanCodeReady(scanCodeReady),
    .asciiKeyAddress(asciiKeyAddress), .asciiKeyValue(asciiKeyValue), .charData(charData),
    .charValid(charValid), .charPop(charPop), .fifoCount(fifoCount), .overflow(overflow),
    .modifiers(modifiers));

  ps2_keyboard_ascii_buffer #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW), .REPEAT_ENABLE(0)) dut_nr (
    .clk(clk), .rst(rst), .scanCode(scanCode), .scanCodeReady(scanCodeReady),
    .asciiKeyAddress(asciiKeyAddress), .asciiKeyValue(key_value_nr), .charData(char_data_nr),
    .charValid(char_valid_nr), .charPop(charPop), .fifoCount(fifo_count_nr), .overflow(overflow_nr),
    .modifiers(modifiers_nr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_key(input bit ext, input bit brk, input logic [7:0] c);
    logic [7:0] b;
    bit mk;
    mk = !brk;
    if (!ext && c == 8'h12) m_ls = mk;
    if (!ext && c == 8'h59) m_rs = mk;
    if (c == 8'h14) begin if (ext) m_rc = mk; else m_lc = mk; end
    if (c == 8'h11) begin if (ext) m_ra = mk; else m_la = mk; end
    if (!ext && c == 8'h58) begin
      if (mk && !m_caps_h) m_caps = !m_caps;
      m_caps_h = mk;
    end
    b = ext ? etbl[c] : tbl[c];
    if (b == 8'h00) return;
    if (mk) begin
      pend = 1;
      if (b >= 8'h61 && b <= 8'h7A)
        pend_c = (m_lc || m_rc) ? b - 8'h60 : ((m_ls || m_rs) != m_caps) ? b - 8'h20 : b;
      else
        pend_c = (m_ls || m_rs) ? stbl[b] : b;
    end
    m_held[b] = mk;
  endtask

  task automatic model_step();
    if (rst) begin
      q.delete();
      m_held = '0;
      {m_ext, m_brk, m_ls, m_rs, m_lc, m_rc, m_la, m_ra, m_caps, m_caps_h, m_ovf} = '0;
      m_key = 0;
      m_valid = 1;
      return;
    end
    m_key = {31'b0, m_held[asciiKeyAddress]};
    pend = 0;
    if (scanCodeReady) begin
      if (!m_ext && !m_brk && scanCode == 8'hE0) m_ext = 1;
      else if (!m_brk && scanCode == 8'hF0) m_brk = 1;
      else begin
        model_key(m_ext, m_brk, scanCode);
        m_ext = 0;
        m_brk = 0;
      end
    end
    if (charPop && q.size() > 0) void'(q.pop_front());
    if (pend) begin
      if (q.size() < DEPTH) q.push_back(pend_c);
      else m_ovf = 1;
    end
  endtask

  initial begin
    foreach (tbl[i]) begin
      tbl[i] = 8'h00;
      etbl[i] = 8'h00;
      stbl[i] = 8'(i);
    end
    for (int i = 0; i < 26; i++) tbl[LET_SC[i]] = 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) begin
      tbl[DIG_SC[i]] = 8'h30 + 8'(i);
      stbl[8'h30 + 8'(i)] = DIG_SH[i];
    end
    for (int i = 0; i < 11; i++) begin
      tbl[PUN_SC[i]] = PUN_B[i];
      stbl[PUN_B[i]] = PUN_S[i];
    end
    tbl[8'h29] = 8'h20; tbl[8'h5A] = 8'h0D; tbl[8'h66] = 8'h08; tbl[8'h0D] = 8'h09;
    etbl[8'h75] = 8'h80; etbl[8'h72] = 8'h81; etbl[8'h6B] = 8'h82; etbl[8'h74] = 8'h83;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("charValid", {31'b0, charValid}, {31'b0, q.size() > 0});
        if (q.size() > 0) check("charData", {24'b0, charData}, {24'b0, q[0]});
        check("fifoCount", 32'(fifoCount), 32'(q.size()));
        check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        check("modifiers", {28'b0, modifiers}, {28'b0, m_caps, m_la | m_ra, m_lc | m_rc, m_ls | m_rs});
        check("asciiKeyValue", asciiKeyValue, m_key);
      end
      model_step();
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    scanCode = c;
    scanCodeReady = 1;
    tick();
    scanCodeReady = 0;
  endtask

  task automatic pop();
    charPop = 1;
    tick();
    charPop = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic peek(input logic [7:0] a, input logic exp, input string name);
    asciiKeyAddress = a;
    tick();
    check(name, asciiKeyValue, {31'b0, exp});
  endtask

  initial begin
    tick(2);
    rst = 0;
    check("rst_count", 32'(fifoCount), 0);
    check("rst_valid", {31'b0, charValid}, 0);
    check("rst_data", {24'b0, charData}, 0);
    check("rst_ovf", {31'b0, overflow}, 0);
    check("rst_mod", {28'b0, modifiers}, 0);
    check("rst_key", asciiKeyValue, 0);

    send(8'h1C);
    check("t1_data", {24'b0, charData}, 32'h61);
    check("t1_valid", {31'b0, charValid}, 1);
    check("t1_count", 32'(fifoCount), 1);
    check("t1_nr_data", {24'b0, char_data_nr}, 32'h61);
    peek(8'h61, 1'b1, "t1_held");
    check("t1_nr_held", key_value_nr, 1);
    send(8'hF0); send(8'h1C);
    check("t1_brk_count", 32'(fifoCount), 1);
    peek(8'h61, 1'b0, "t1_released");

    do_reset();
    send(8'h12); send(8'h1E);
    check("t2_at", {24'b0, charData}, 32'h40);
    pop();
    send(8'hF0); send(8'h12); send(8'h1E);
    check("t2_repeat", {24'b0, charData}, 32'h32);
    check("t2_repeat_count", 32'(fifoCount), 1);
    check("t2_norep_count", 32'(fifo_count_nr), 0);
    check("t2_norep_valid", {31'b0, char_valid_nr}, 0);
    check("t2_norep_mod", {28'b0, modifiers_nr}, 0);

    do_reset();
    send(8'h58);
    check("t3_caps_mod", {28'b0, modifiers}, 32'h8);
    send(8'hF0); send(8'h58); send(8'h15);
    check("t3_Q", {24'b0, charData}, 32'h51);
    pop();
    send(8'h12); send(8'h15);
    check("t3_q", {24'b0, charData}, 32'h71);
    check("t3_mod", {28'b0, modifiers}, 32'h9);

    do_reset();
    send(8'hE0); send(8'h75);
    check("t4_up", {24'b0, charData}, 32'h80);
    peek(8'h80, 1'b1, "t4_held");
    send(8'hE0); send(8'hF0); send(8'h75);
    peek(8'h80, 1'b0, "t4_released");
    pop();
    send(8'hE0);
    do_reset();
    send(8'h75);
    check("t4_rst_count", 32'(fifoCount), 0);
    peek(8'h80, 1'b0, "t4_rst_held");

    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    check("t5_full_count", 32'(fifoCount), 4);
    check("t5_ovf", {31'b0, overflow}, 1);
    check("t5_nr_ovf", {31'b0, overflow_nr}, 1);
    check("t5_head", {24'b0, charData}, 32'h61);
    repeat (4) pop();
    check("t5_empty_valid", {31'b0, charValid}, 0);
    pop();
    check("t5_empty_pop", 32'(fifoCount), 0);
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    check("t5_refill", 32'(fifoCount), 4);
    scanCode = 8'h2B;
    scanCodeReady = 1;
    charPop = 1;
    tick();
    scanCodeReady = 0;
    charPop = 0;
    check("t5_pushpop_count", 32'(fifoCount), 4);
    check("t5_pushpop_ovf", {31'b0, overflow}, 0);
    check("t5_pushpop_head", {24'b0, charData}, 32'h62);

    do_reset();
    send(8'h14); send(8'h21);
    check("t6_ctrl_c", {24'b0, charData}, 32'h03);
    check("t6_ctrl_mod", {28'b0, modifiers}, 32'h2);
    send(8'h12); send(8'h59); send(8'hF0); send(8'h12);
    check("t6_shift_kept", {28'b0, modifiers}, 32'h3);
    send(8'hF0); send(8'h59);
    check("t6_shift_off", {28'b0, modifiers}, 32'h2);

    do_reset();
    for (int i = 0; i < 56; i++) begin
      charPop = i[0];
      send(SEQ[i]);
    end
    charPop = 0;
    asciiKeyAddress = 8'h6F;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_ascii_buffer.md
Name: ps2_keyboard_ascii_buffer

Overview:
Parametrised successor to the keyboard memory block. It consumes PS/2 set-2 scan codes and tracks make/break, E0-extended and modifier state. It keeps a per-ASCII "key held" bitmap that the CPU can read by address, and it queues translated, shift-aware characters in a FIFO with a pop handshake. It sits between the PS/2 receiver and the CPU memory-mapped I/O bus.

Parameters:
FIFO_DEPTH, 16, character queue depth; power of two, minimum 2.
DATA_WIDTH, 32, width of the bus read word; minimum 8.
REPEAT_ENABLE, 1, if 1 a make code for an already-held key is queued again (typematic); if 0 it is not queued.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
scanCode  in  8  byte from the PS/2 receiver
scanCodeReady  in  1  one-cycle strobe; scanCode is valid this cycle
asciiKeyAddress  in  8  ASCII code to query in the held bitmap
asciiKeyValue  out  DATA_WIDTH  {zeros, held[asciiKeyAddress]}
charData  out  8  FIFO head character (show-ahead)
charValid  out  1  FIFO not empty
charPop  in  1  consume the head; ignored when empty
fifoCount  out  $clog2(FIFO_DEPTH)+1  number of queued characters
overflow  out  1  sticky; a character was dropped because the FIFO was full
modifiers  out  4  {capsLock, alt, ctrl, shift}

Behaviour:
- One clock and one synchronous active-high reset. All state advances only on clk edges where scanCodeReady, charPop or rst is high.
- Reset values: asciiKeyValue=0, charData=0, charValid=0, fifoCount=0, overflow=0, modifiers=0.
- Reset clears the held bitmap, the FIFO and the decoder state. Reset asserted mid-sequence (for example after E0) discards the partial sequence.

Decoder FSM (one transition per scanCodeReady):
- IDLE: E0 -> EXT; F0 -> BRK; any other byte is a make; stay in IDLE.
- EXT: F0 -> EXT_BRK; any other byte is an extended make; return to IDLE.
- BRK: any byte is a break; return to IDLE.
- EXT_BRK: any byte is an extended break; return to IDLE.
- E0 received in BRK or EXT_BRK: treated as a break of the code E0, which is unmapped, so it is ignored; return to IDLE.

Translation map:
- Base (unshifted) code: letters -> lowercase; digits and punctuation -> unshifted glyph; space=20h; enter=0Dh; backspace=08h; tab=09h.
- Extended keys: up=80h, down=81h, left=82h, right=83h.
- Shifted glyph (shift XOR capsLock for letters; shift only for everything else): uppercase letters, US-layout symbols !@#$%^&*()_+{}|:"<>?.
- Unmapped codes leave every piece of state unchanged except the FSM.

Make handling:
- Set held[base].
- Queue the shifted glyph if the key was not already held, or if it was held and REPEAT_ENABLE=1.
- Modifier keys are never queued: 12h/59h (shift), 14h and E0 14h (ctrl), 11h and E0 11h (alt).
- Caps lock 58h toggles capsLock only on its first make, not on repeats.

Break handling:
- Clear held[base].
- Shift is the OR of separate left and right flags, so releasing one shift keeps shift asserted while the other is held. Ctrl and alt are tracked the same way (left and right flags, ORed).

Ctrl:
- With ctrl=1, a letter queues its control code (ASCII & 1Fh), for example ctrl+c -> 03h.

Timing:
- A character is queued on the edge that samples scanCodeReady. charValid and charData reflect it on the next cycle (1-cycle latency).
- asciiKeyValue is registered; it reflects held[] for the address presented one cycle earlier.

FIFO:
- Push when full: the character is dropped and overflow is set until reset.
- Push and pop in the same cycle when full: both happen, so count is unchanged and overflow is not set.
- Push and pop in the same cycle when empty: the push happens and the pop is ignored.
- Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package ps2_keyboard_pkg holds:
  - the ScanCodes enum, plus new entries SC_PREFIX_EXT=E0h, SC_PREFIX_BREAK=F0h and sc_capslock=58h;
  - the AsciiCodes enum, plus the extended-arrow codes 80h-83h;
  - the decoder-state enum;
  - the base-map and shift-map functions.
- Sub-module ps2_char_fifo (params DEPTH, WIDTH) implements the show-ahead FIFO with count, full and empty.

Test Plan:
1. Reset, then send 1Ch -> charData=61h ('a') one cycle later, charValid=1, fifoCount=1, held[61h]=1. Then send F0 1Ch -> held[61h]=0 and no new character is queued.
2. Send 12h, then 1Eh -> queued 40h ('@'). Then F0 12h, then 1Eh again (already held) -> queued 32h ('2') when REPEAT_ENABLE=1; nothing queued when REPEAT_ENABLE=0.
3. Send 58h, F0 58h, then 15h -> queued 51h ('Q'). Then 12h, 15h -> queued 71h ('q'), since shift XOR caps gives lowercase.
4. Send E0 75h -> queued 80h and held[80h]=1. Then E0 F0 75h -> held[80h]=0. Send E0, then assert rst, then send 75h -> decoded as an unmapped plain make: nothing queued, held[80h]=0.
5. With FIFO_DEPTH=4, send 5 distinct makes -> fifoCount=4 and overflow=1. Then pop 4 times -> charValid=0. Then pop on empty -> fifoCount stays 0. Also check simultaneous push and pop on a full FIFO -> fifoCount stays 4 and overflow is not newly set.
6. Hold 14h, then send 21h -> queued 03h (ctrl+c) and modifiers=0010b. Hold 12h and 59h, release 12h -> shift remains 1.
